// File: rtl/fm_pkg.sv
// fm_pkg: Q10 constants, fixed-point multiply and FSM states shared by the FM discriminator
package fm_pkg;
  localparam int FRAC = 10;
  localparam logic [31:0] QUAD1 = 32'd804;
  localparam logic [31:0] QUAD3 = 32'd2412;
  localparam logic [31:0] GAIN = 32'd758;
  typedef enum logic [2:0] {READ, MULT, DIV, ANGLE, WRITE} state_t;
  function automatic logic signed [31:0] mul_q10(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] p;
    p = a * b;
    return p[FRAC+31:FRAC];
  endfunction
endpackage

// File: rtl/fm_div.sv
// fm_div: sequential signed restoring divider, one quotient bit per cycle, truncates toward zero
module fm_div #(
  parameter int W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic signed [W-1:0] dividend,
  input  logic signed [W-1:0] divisor,
  output logic signed [W-1:0] quotient,
  output logic                done
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction
  logic [W-1:0] rem, acc, dm, src_rem, src_acc, src_d, nrem, nacc;
  logic [W:0] trial, diff;
  logic [CW-1:0] cnt;
  logic neg, busy, fits;
  // the start cycle already performs the first step so done lands W cycles after start
  always_comb begin
    src_rem = start ? '0 : rem;
    src_acc = start ? mag(dividend) : acc;
    src_d = start ? mag(divisor) : dm;
    trial = {src_rem, src_acc[W-1]};
    diff = trial - {1'b0, src_d};
    fits = !diff[W];
    nrem = fits ? diff[W-1:0] : trial[W-1:0];
    nacc = {src_acc[W-2:0], fits};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rem <= '0;
      acc <= '0;
      dm <= '0;
      neg <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      done <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= nrem;
        acc <= nacc;
        dm <= src_d;
        neg <= dividend[W-1] ^ divisor[W-1];
        cnt <= CW'(1);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= nrem;
        acc <= nacc;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
          quotient <= neg ? -nacc : nacc;
        end
      end
    end
  end
endmodule

// File: rtl/fm_demod.sv
// fm_demod: polar FM discriminator (conjugate product, Q10 quarter-arctangent via divider)
// FM_DEMOD_GAIN_EN defined scales the angle by GAIN; undefined outputs raw Q10 radians.
module fm_demod
  import fm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [31:0] GAIN = fm_pkg::GAIN,
  parameter logic [31:0] QUAD1 = fm_pkg::QUAD1,
  parameter logic [31:0] QUAD3 = fm_pkg::QUAD3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] real_in,
  input  logic                  real_empty,
  output logic                  real_rd_en,
  input  logic [DATA_WIDTH-1:0] imag_in,
  input  logic                  imag_empty,
  output logic                  imag_rd_en,
  output logic [DATA_WIDTH-1:0] demod_out,
  output logic                  demod_wr_en,
  input  logic                  demod_full
);
  state_t state;
  logic signed [DATA_WIDTH-1:0] cur_re, cur_im, prev_re, prev_im, x, y, num, den, q, q_div, result;
  logic signed [DATA_WIDTH-1:0] xm, ym, ay, num_m, den_m, a_base, a, result_c;
  logic div_start, div_done, rd;
  always_comb begin
    xm = mul_q10(prev_re, cur_re) + mul_q10(prev_im, cur_im);
    ym = mul_q10(prev_re, cur_im) - mul_q10(prev_im, cur_re);
    ay = (ym < 0 ? -ym : ym) + 1;
    num_m = (xm >= 0 ? xm - ay : xm + ay) <<< FRAC;
    den_m = xm >= 0 ? xm + ay : ay - xm;
    a_base = (x >= 0 ? $signed(QUAD1) : $signed(QUAD3)) - mul_q10($signed(QUAD1), q);
    a = y < 0 ? -a_base : a_base;
`ifdef FM_DEMOD_GAIN_EN
    result_c = mul_q10($signed(GAIN), a);
`else
    result_c = a;
`endif
  end
`ifndef FM_DEMOD_GAIN_EN
  logic unused_gain;
  assign unused_gain = ^GAIN;
`endif
  assign rd = state == READ && !real_empty && !imag_empty && !reset;
  assign real_rd_en = rd;
  assign imag_rd_en = rd;
  assign demod_wr_en = state == WRITE && !demod_full && !reset;
  assign demod_out = demod_wr_en ? result : '0;
  fm_div #(.W(DATA_WIDTH)) u_div (
    .clock(clock),
    .reset(reset),
    .start(div_start),
    .dividend(num),
    .divisor(den),
    .quotient(q_div),
    .done(div_done)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= READ;
      cur_re <= '0;
      cur_im <= '0;
      prev_re <= '0;
      prev_im <= '0;
      x <= '0;
      y <= '0;
      num <= '0;
      den <= '0;
      q <= '0;
      result <= '0;
      div_start <= 1'b0;
    end else begin
      case (state)
        READ: if (rd) begin
          cur_re <= real_in;
          cur_im <= imag_in;
          state <= MULT;
        end
        MULT: begin
          prev_re <= cur_re;
          prev_im <= cur_im;
          x <= xm;
          y <= ym;
          num <= num_m;
          den <= den_m;
          div_start <= 1'b1;
          state <= DIV;
        end
        DIV: begin
          div_start <= 1'b0;
          if (div_done) begin
            q <= q_div;
            state <= ANGLE;
          end
        end
        ANGLE: begin
          result <= result_c;
          state <= WRITE;
        end
        WRITE: if (!demod_full) state <= READ;
        default: state <= READ;
      endcase
    end
  end
endmodule

// File: doc/fm_demod.md
# fm_demod

Polar FM discriminator stage that sits directly downstream of the complex channel FIR. It pops one filtered I/Q pair per handshake from the real/imag output FIFOs. It forms the conjugate product with the previous sample and computes its phase with a Q10 quarter-arctangent, using an iterative divider. It pushes one signed Q10 demodulated sample per input pair to the audio-path FIFO.

## Interface
- DATA_WIDTH, 32, sample and result width (two's complement, 10 fractional bits)
- GAIN, 32'd758, demodulator gain in Q10 (256 kHz / (2π·55 kHz) ≈ 0.7407)
- QUAD1, 32'd804, π/4 in Q10
- QUAD3, 32'd2412, 3π/4 in Q10
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- real_in  input  DATA_WIDTH  FIFO head, real part
- real_empty  input  1  real FIFO empty
- real_rd_en  output  1  pop real FIFO (reset 0)
- imag_in  input  DATA_WIDTH  FIFO head, imag part
- imag_empty  input  1  imag FIFO empty
- imag_rd_en  output  1  pop imag FIFO (reset 0)
- demod_out  output  DATA_WIDTH  demodulated sample, 0 when not writing (reset 0)
- demod_wr_en  output  1  push output FIFO (reset 0)
- demod_full  input  1  output FIFO full

## Operation
- mul(a,b) = ($signed(a)·$signed(b)) >>> 10, truncated to 32 bits (floor rounding).
- Registers prev_real and prev_imag reset to 0 and load the popped sample every READ.
- States:
  - READ: if !real_empty && !imag_empty, assert real_rd_en = imag_rd_en = 1 in the same cycle, latch cur, then go to MULT. Otherwise hold with rd_en = 0.
  - MULT:
    - x = mul(prev_real,cur_real) + mul(prev_imag,cur_imag)
    - y = mul(prev_real,cur_imag) − mul(prev_imag,cur_real)
    - prev ← cur
    - abs_y = |y| + 1
    - if x ≥ 0: num = (x − abs_y) << 10, den = x + abs_y
    - else: num = (x + abs_y) << 10, den = abs_y − x
    - Truncate both to 32 bits, then go to DIV.
  - DIV: one-cycle div_start, then wait for div_done. Quotient q is signed and truncates toward zero; den ≥ 1 by construction.
  - ANGLE:
    - a = QUAD1 − mul(QUAD1,q) if x ≥ 0, else QUAD3 − mul(QUAD1,q)
    - negate a if y < 0
    - result = mul(GAIN,a) (see Configuration)
  - WRITE: if !demod_full, demod_wr_en = 1 and demod_out = result, then go to READ. Otherwise hold with wr_en = 0 and demod_out = 0.
- x, y, q and the sign flags are held registered between states.

## Timing
- The rd_en cycle is T. MULT occurs at T+1, div_start at T+2, and div_done at T+34 (32 quotient bits, one per cycle). ANGLE occurs at T+35, and the earliest demod_wr_en is at T+36.
- Throughput is one sample per 37 cycles. Only one sample is in flight; no pop occurs until WRITE completes.
- Full on entry to WRITE stalls indefinitely with no data loss. Empty on either FIFO holds READ, and the block never pops one FIFO without the other.
- Reset asserted in any state returns to READ on the next edge, clears prev, aborts the divider, and drives all outputs to 0. The in-flight sample is discarded.

## Configuration
- FM_DEMOD_GAIN_EN defined: result = mul(GAIN, a).
- FM_DEMOD_GAIN_EN undefined: result = a (raw Q10 radians); the GAIN parameter is ignored and no gain multiplier is synthesized.
- Latency is identical in both builds.

## Structure
- Shared package fm_pkg holds:
  - the Q10 constants QUAD1, QUAD3, GAIN, and the fractional-bit count 10
  - mul_q10 function
  - demod state enum {READ, MULT, DIV, ANGLE, WRITE}
- Sub-module fm_div: sequential signed restoring divider with ports clock, reset, start, dividend, divisor, quotient, and done (one-cycle pulse). It takes magnitudes internally and applies the sign on completion.

## Test plan
- Reset, then push a single pair (0,0) with prev = 0 → first output 1190 at T+36 (1608 without FM_DEMOD_GAIN_EN).
- Push pairs (1024,0) then (1024,0) → second output 1 (raw 2).
- Push pairs (1024,0) then (0,1024) → second output 1190 (raw 1608).
- Push pairs (1024,0) then (0,−1024) → second output −1191 (raw −1608).
- Hold demod_full high for 100 cycles during WRITE → wr_en stays 0 and rd_en stays 0; on release, exactly one write of the held value.
- Assert reset at T+20 mid-division → outputs are 0 next cycle, no write occurs, prev is cleared, and the next pair produces the first-sample result.
